counter_seq_checker: RTL
========================

# counter_seq_checker

Receive-side checker for the 4-bit run/pause pattern counter. It samples the counter's `q`, `oe` and `en` every clock and locks onto the pattern. Once locked, it verifies the step sequence 0,2,4,5,7,9 over `RUN_LAPS` run laps, followed by `PAUSE_LAPS` pause laps. It reports lock status, per-frame completion and errors, and sits beside the counter in board-level and bench integration.

## Interface
Parameters:
- `RUN_LAPS`, 3, run laps per frame (1..7)
- `PAUSE_LAPS`, 2, pause laps per frame (1..7)
- `CNTW`, 8, width of the error and frame counters

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `q`  in  4  counter value under check
- `oe`  in  1  counter output enable; 1 during run laps, 0 during pause laps
- `en`  in  1  counter step strobe; only cycles with `en`=1 are checked
- `locked`  out  1  checker is aligned to the pattern
- `err`  out  1  one-cycle pulse on a mismatch while locked
- `frame_done`  out  1  one-cycle pulse when the last pause step of a frame is accepted
- `err_cnt`  out  CNTW  mismatch count, saturating
- `frame_cnt`  out  CNTW  completed frames, wrapping
- `exp_q`  out  4  value expected at the next `en`=1 run step

## Operation
- Step table `SEQ[0..5]` = 0,2,4,5,7,9. A lap is 6 accepted steps. A frame is `RUN_LAPS` run laps followed by `PAUSE_LAPS` pause laps.
- Cycles with `en`=0 are ignored entirely: no check, no state advance, no output pulse.
- States and transitions:
  - HUNT: `locked`=0. An `en`=1 sample with `oe`=1 and `q`=0 moves to RUN with step=1, lap=0. Any other sample stays in HUNT and raises no error.
  - RUN: every `en`=1 sample must show `oe`=1 and `q`=`SEQ[step]`. Step wraps 5→0 and then increments lap. Accepting step 5 of lap `RUN_LAPS`-1 moves to PAUSE with step=0, lap=0.
  - PAUSE: every `en`=1 sample must show `oe`=0. `q` is not checked. Accepting the last step of lap `PAUSE_LAPS`-1 pulses `frame_done`, increments `frame_cnt` and moves to RUN with step=0, lap=0.
- Mismatch in RUN or PAUSE:
  - pulse `err`, increment `err_cnt` (saturating at all-ones), go to HUNT.
  - The offending sample is not re-used for lock; re-lock requires a later `en`=1, `oe`=1, `q`=0 sample.
- `exp_q`:
  - RUN: `SEQ[step]`.
  - HUNT: 0.
  - PAUSE: 0, and also 0 on the transition back to RUN.
- `locked`=1 in RUN and PAUSE.
- Values of `q` above 9 are ordinary mismatches.

## Timing
- All outputs are registered. The response to the sample at edge N appears after edge N, so the latency is 1 cycle.
- `err` and `frame_done` are high for exactly one cycle. They never coincide.
- Reset values: state HUNT, `locked`=0, `err`=0, `frame_done`=0, `err_cnt`=0, `frame_cnt`=0, `exp_q`=0, step=0, lap=0.
- Reset asserted mid-frame clears everything immediately and asynchronously. After release, the first edge evaluates in HUNT.
- A valid lock sample one cycle after an error sample is accepted, because HUNT is already active on that edge.
- At `err_cnt` saturation, `err` still pulses.
- `frame_cnt` wraps from all-ones to 0.

## Structure
- Shared package `counter_pattern_pkg`: `SEQ` table, `STEPS`=6, default `RUN_LAPS`/`PAUSE_LAPS`, state enum {HUNT, RUN, PAUSE}. The counter itself uses the same package.
- Sub-module `seq_step_rom`: 3-bit step index in, 4-bit value out, combinational. It is used for both the compare and `exp_q`.
- Top level holds the FSM, step/lap counters and the two statistics counters.

## Test plan
- Clean stream, `en`=1 every cycle, starting q=0 in run: `locked`=1 from cycle 2; `frame_done` pulses every 30 cycles; `frame_cnt`=3 after 90 cycles; `err_cnt`=0.
- Same stream with `en` deasserted every other cycle and `q` held: identical results at half rate; no `err`.
- Corrupt the third step of run lap 2 (`q`=3 instead of 4): one `err` pulse; `err_cnt`=1; `locked`=0; re-lock at the next run-lap start; `frame_cnt` not incremented for that frame.
- `oe`=1 on a pause step: `err` pulse, HUNT; a garbage stream of `q`=15 never locks and raises no further errors.
- Assert `reset` low for 3 cycles in mid-pause: all outputs 0 immediately; after release, lock on the next `q`=0 run sample.
- Force 300 errors with `CNTW`=8: `err_cnt` stays at 255; `err` pulses every time.

Source files
------------

// File: rtl/counter_pattern_pkg.sv
// Shared definitions for the 4-bit run/pause pattern counter and its
// receive-side checker: step table, lap defaults and FSM state encoding.
package counter_pattern_pkg;

  localparam int STEPS           = 6;
  localparam int RUN_LAPS_DEF    = 3;
  localparam int PAUSE_LAPS_DEF  = 2;

  // Step table, element [k] is SEQ[k]: 0,2,4,5,7,9
  localparam logic [STEPS-1:0][3:0] SEQ = {4'd9, 4'd7, 4'd5, 4'd4, 4'd2, 4'd0};

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_step_rom.sv
// Combinational step-value lookup.
//   idx : 3-bit step index (0..5 valid)
//   val : SEQ[idx]; 0 for unused indices 6,7
module seq_step_rom
  import counter_pattern_pkg::*;
(
  input  logic [2:0] idx,
  output logic [3:0] val
);

  always_comb begin
    val = 4'd0;
    case (idx)
      3'd0: val = SEQ[0];
      3'd1: val = SEQ[1];
      3'd2: val = SEQ[2];
      3'd3: val = SEQ[3];
      3'd4: val = SEQ[4];
      3'd5: val = SEQ[5];
      default: val = 4'd0;
    endcase
  end

endmodule

// File: rtl/counter_seq_checker.sv
// Receive-side checker for the run/pause pattern counter. Locks on a
// q=0 run sample, then checks RUN_LAPS laps of 0,2,4,5,7,9 with oe=1
// followed by PAUSE_LAPS laps with oe=0. Only en=1 cycles are evaluated.
//   clk, reset      : clock, async active-low reset
//   q, oe, en       : counter value, output enable, step strobe
//   locked          : aligned to the pattern (RUN or PAUSE)
//   err             : 1-cycle pulse on a mismatch while locked
//   frame_done      : 1-cycle pulse on the last pause step of a frame
//   err_cnt         : saturating mismatch count
//   frame_cnt       : wrapping completed-frame count
//   exp_q           : value expected at the next run step
module counter_seq_checker
  import counter_pattern_pkg::*;
#(
  parameter int RUN_LAPS   = RUN_LAPS_DEF,
  parameter int PAUSE_LAPS = PAUSE_LAPS_DEF,
  parameter int CNTW       = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [3:0]      q,
  input  logic            oe,
  input  logic            en,
  output logic            locked,
  output logic            err,
  output logic            frame_done,
  output logic [CNTW-1:0] err_cnt,
  output logic [CNTW-1:0] frame_cnt,
  output logic [3:0]      exp_q
);

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);
  localparam logic [2:0] RUN_LAST  = 3'(RUN_LAPS - 1);
  localparam logic [2:0] PAUSE_LAST = 3'(PAUSE_LAPS - 1);

  state_t     state, state_n;
  logic [2:0] step, step_n;
  logic [2:0] lap, lap_n;
  logic       err_n, fd_n;
  logic [3:0] cur_val, nxt_val;

  // One lookup for the compare, one for the registered expectation
  seq_step_rom u_rom_cur (.idx(step),   .val(cur_val));
  seq_step_rom u_rom_nxt (.idx(step_n), .val(nxt_val));

  always_comb begin
    state_n = state;
    step_n  = step;
    lap_n   = lap;
    err_n   = 1'b0;
    fd_n    = 1'b0;
    if (en) begin
      case (state)
        HUNT: begin
          // lock sample is itself step 0, so the next expected step is 1
          if (oe && q == 4'd0) begin
            state_n = RUN;
            step_n  = 3'd1;
            lap_n   = 3'd0;
          end
        end
        RUN: begin
          if (oe && q == cur_val) begin
            if (step == LAST_STEP) begin
              step_n = 3'd0;
              if (lap == RUN_LAST) begin
                state_n = PAUSE;
                lap_n   = 3'd0;
              end else begin
                lap_n = lap + 3'd1;
              end
            end else begin
              step_n = step + 3'd1;
            end
          end else begin
            err_n   = 1'b1;
            state_n = HUNT;
            step_n  = 3'd0;
            lap_n   = 3'd0;
          end
        end
        PAUSE: begin
          if (!oe) begin
            if (step == LAST_STEP) begin
              step_n = 3'd0;
              if (lap == PAUSE_LAST) begin
                fd_n    = 1'b1;
                state_n = RUN;
                lap_n   = 3'd0;
              end else begin
                lap_n = lap + 3'd1;
              end
            end else begin
              step_n = step + 3'd1;
            end
          end else begin
            err_n   = 1'b1;
            state_n = HUNT;
            step_n  = 3'd0;
            lap_n   = 3'd0;
          end
        end
        default: begin
          state_n = HUNT;
          step_n  = 3'd0;
          lap_n   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= HUNT;
      step       <= 3'd0;
      lap        <= 3'd0;
      locked     <= 1'b0;
      err        <= 1'b0;
      frame_done <= 1'b0;
      err_cnt    <= '0;
      frame_cnt  <= '0;
      exp_q      <= 4'd0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      lap        <= lap_n;
      locked     <= (state_n != HUNT);
      err        <= err_n;
      frame_done <= fd_n;
      exp_q      <= (state_n == RUN) ? nxt_val : 4'd0;
      if (err_n && err_cnt != '1)
        err_cnt <= err_cnt + 1'b1;
      if (fd_n)
        frame_cnt <= frame_cnt + 1'b1;
    end
  end

endmodule
